fetch_seq_ctrl: RTL and testbench

- Sequences instruction fetch for the RV32 core.
- Owns the architectural PC register and issues one instruction-memory request at a time over a valid/ready request channel with a response-valid return.
- Hands fetched instructions to decode via a valid/ready handshake.
- Applies execute-stage redirects with the same three next-PC selections as the core's next-PC mux: PC+4, PC+imm, rs1+imm.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/pc_target_calc.sv | 23 ++
 rtl/fetch_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_fetch_seq_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer and execute-stage target logic.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10,
        HALT = 2'b11
    } fetch_state_t;

    // Next-PC select, encoded as {pcasrc, pcbsrc}
    localparam logic [1:0] PCSEL_SEQ    = 2'b00;
    localparam logic [1:0] PCSEL_PCIMM  = 2'b10;
    localparam logic [1:0] PCSEL_RS1IMM = 2'b11;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    function automatic logic is_redirect(input logic [1:0] pcsel);
        return (pcsel == PCSEL_PCIMM) || (pcsel == PCSEL_RS1IMM);
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target adder: pc+imm or rs1+imm with wraparound, plus word-misalignment flag.
module pc_target_calc
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            pcbsrc,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_imm,
    input  logic [XLEN-1:0] br_rs1,
    output logic [XLEN-1:0] target,
    output logic            misalign
);

    logic [XLEN-1:0] base;

    always_comb begin
        base     = pcbsrc ? br_rs1 : br_pc;
        target   = base + br_imm;
        misalign = (target[1:0] != 2'b00);
    end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one imem request at a time and
// hands each fetched word to decode, honouring execute-stage redirects.
//
//  state | meaning
//  REQ   | request valid with addr=pc, waiting for imem accept
//  WAIT  | one request outstanding, waiting for its response
//  HOLD  | instruction presented to decode, waiting for inst_ready
//  HALT  | misaligned redirect taken; fetch stopped until reset
module fetch_seq_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            br_valid,
    input  logic            br_pcasrc,
    input  logic            br_pcbsrc,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_imm,
    input  logic [XLEN-1:0] br_rs1,
    output logic [XLEN-1:0] pc,
    output logic            misalign_err
);

    fetch_state_t    state;
    logic            drop;
    logic            halt_pend;
    logic [XLEN-1:0] tgt;
    logic            tgt_mis;
    logic            redirect;
    logic            req_fire;

    pc_target_calc #(.XLEN(XLEN)) u_tgt (
        .pcbsrc   (br_pcbsrc),
        .br_pc    (br_pc),
        .br_imm   (br_imm),
        .br_rs1   (br_rs1),
        .target   (tgt),
        .misalign (tgt_mis)
    );

    assign redirect      = br_valid && is_redirect({br_pcasrc, br_pcbsrc});
    assign req_fire      = imem_req_valid && imem_req_ready;
    assign imem_req_addr = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= REQ;
            pc             <= RESET_PC;
            imem_req_valid <= 1'b0;
            inst_valid     <= 1'b0;
            inst           <= '0;
            inst_pc        <= '0;
            misalign_err   <= 1'b0;
            drop           <= 1'b0;
            halt_pend      <= 1'b0;
        end else begin
            if (redirect && state != HALT) begin
                pc <= tgt;
                if (tgt_mis) misalign_err <= 1'b1;
            end

            case (state)
                REQ: begin
                    // valid is low for the first cycle out of reset; raise it here
                    imem_req_valid <= 1'b1;
                    if (req_fire) begin
                        imem_req_valid <= 1'b0;
                        state          <= WAIT;
                        if (redirect) begin
                            drop      <= 1'b1;
                            halt_pend <= tgt_mis;
                        end
                    end else if (redirect && tgt_mis) begin
                        imem_req_valid <= 1'b0;
                        state          <= HALT;
                    end
                end

                WAIT: begin
                    if (imem_rsp_valid && (redirect || drop)) begin
                        drop <= 1'b0;
                        if (halt_pend || (redirect && tgt_mis)) begin
                            state <= HALT;
                        end else begin
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        inst       <= imem_rsp_data;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        state      <= HOLD;
                    end else if (redirect) begin
                        drop <= 1'b1;
                        if (tgt_mis) halt_pend <= 1'b1;
                    end
                end

                HOLD: begin
                    if (redirect) begin
                        inst_valid <= 1'b0;
                        if (tgt_mis) begin
                            state <= HALT;
                        end else begin
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                        end
                    end else if (inst_ready) begin
                        pc             <= pc + 32'd4;
                        inst_valid     <= 1'b0;
                        state          <= REQ;
                        imem_req_valid <= 1'b1;
                    end
                end

                HALT: begin
                    imem_req_valid <= 1'b0;
                    inst_valid     <= 1'b0;
                end

                default: state <= REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl with hand-computed expectations checked by immediate assertions.
module tb_fetch_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        br_valid;
    logic        br_pcasrc;
    logic        br_pcbsrc;
    logic [31:0] br_pc;
    logic [31:0] br_imm;
    logic [31:0] br_rs1;
    logic [31:0] pc;
    logic        misalign_err;

    int checks   = 0;
    int failures = 0;

    fetch_seq_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .br_valid       (br_valid),
        .br_pcasrc      (br_pcasrc),
        .br_pcbsrc      (br_pcbsrc),
        .br_pc          (br_pc),
        .br_imm         (br_imm),
        .br_rs1         (br_rs1),
        .pc             (pc),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_br(input logic v, input logic a, input logic b,
                          input logic [31:0] bpc, input logic [31:0] imm, input logic [31:0] rs1);
        br_valid  = v;
        br_pcasrc = a;
        br_pcbsrc = b;
        br_pc     = bpc;
        br_imm    = imm;
        br_rs1    = rs1;
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b0;
        set_br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        tick(); tick(); tick();

        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_misalign", {31'b0, misalign_err}, 32'd0);

        // basic fetch, zero-wait memory
        rst_n = 1'b1; imem_req_ready = 1'b1;
        tick();
        chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h8000_0000);
        tick();
        chk("wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
        tick();
        imem_rsp_valid = 1'b0;
        chk("hold_inst_valid", {31'b0, inst_valid}, 32'd1);
        chk("hold_inst", inst, 32'h0000_0013);
        chk("hold_inst_pc", inst_pc, 32'h8000_0000);

        // decode stall for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_inst", inst, 32'h0000_0013);
            chk("stall_inst_pc", inst_pc, 32'h8000_0000);
            chk("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
            chk("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("seq_req_addr", imem_req_addr, 32'h8000_0004);
        chk("seq_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("seq_inst_valid", {31'b0, inst_valid}, 32'd0);

        // redirect while waiting: response must be discarded
        tick();
        set_br(1'b1, 1'b1, 1'b0, 32'h8000_0010, 32'h0000_0020, 32'h0);
        tick();
        set_br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("wait_redir_pc", pc, 32'h8000_0030);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        chk("drop_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("drop_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("drop_req_addr", imem_req_addr, 32'h8000_0030);

        // redirect in HOLD together with inst_ready: target wins over pc+4
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093;
        tick();
        imem_rsp_valid = 1'b0;
        chk("hold2_inst_pc", inst_pc, 32'h8000_0030);
        chk("hold2_inst", inst, 32'h0010_0093);
        inst_ready = 1'b1;
        set_br(1'b1, 1'b1, 1'b1, 32'h8000_0030, 32'hFFFF_FFFC, 32'h8000_1000);
        tick();
        inst_ready = 1'b0;
        set_br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("hold_redir_addr", imem_req_addr, 32'h8000_0FFC);
        chk("hold_redir_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("hold_redir_inst_valid", {31'b0, inst_valid}, 32'd0);

        // sequential br_valid is a no-op; redirect in REQ without acceptance
        imem_req_ready = 1'b0;
        set_br(1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h0000_0100, 32'h0000_0200);
        tick();
        chk("seq_br_noop_pc", pc, 32'h8000_0FFC);
        set_br(1'b1, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0000_000C, 32'h0);
        tick();
        set_br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("req_redir_addr", imem_req_addr, 32'hFFFF_FFFC);
        chk("req_redir_valid", {31'b0, imem_req_valid}, 32'd1);

        // PC wrap on sequential advance
        imem_req_ready = 1'b1;
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
        tick();
        imem_rsp_valid = 1'b0;
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("wrap_req_addr", imem_req_addr, 32'h0000_0000);

        // reset in the middle of WAIT
        tick();
        chk("pre_rst_wait_valid", {31'b0, imem_req_valid}, 32'd0);
        rst_n = 1'b0;
        tick();
        chk("midrst_addr", imem_req_addr, 32'h8000_0000);
        chk("midrst_inst_valid", {31'b0, inst_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rerst_req_valid", {31'b0, imem_req_valid}, 32'd1);

        // redirect in the same cycle as request acceptance
        set_br(1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_0100, 32'h0);
        tick();
        set_br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("acc_redir_pc", pc, 32'h8000_0100);
        chk("acc_redir_valid", {31'b0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
        tick();
        imem_rsp_valid = 1'b0;
        chk("acc_drop_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("acc_drop_addr", imem_req_addr, 32'h8000_0100);
        chk("acc_drop_valid", {31'b0, imem_req_valid}, 32'd1);

        // misaligned redirect during WAIT halts fetch
        tick();
        set_br(1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 32'h8000_0002);
        tick();
        set_br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("mis_err", {31'b0, misalign_err}, 32'd1);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
        tick();
        imem_rsp_valid = 1'b0;
        chk("mis_inst_valid", {31'b0, inst_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("halt_no_req", {31'b0, imem_req_valid}, 32'd0);
            chk("halt_err_sticky", {31'b0, misalign_err}, 32'd1);
        end
        rst_n = 1'b0;
        tick();
        chk("halt_rst_err", {31'b0, misalign_err}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("halt_rst_req", {31'b0, imem_req_valid}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
